register_file: RTL

General-purpose register file for the single-cycle datapath: 32 registers of N bits, one synchronous write port and two combinational read ports. It sits directly downstream of the address decoders. The write address is expanded by a one-hot decoder tree built from the team's `decoder_1_to_2` cells, and that tree's enabled output gates the per-register write strobes. Register 0 is hardwired to zero, and same-cycle write-to-read forwarding is provided.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/decoder_a_to_2a.sv | 42 ++++
 rtl/register_file.sv | 69 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
package regfile_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_A    = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef logic [DEF_A-1:0] reg_addr_t;
  typedef logic [DEF_N-1:0] reg_word_t;

endpackage

// File: rtl/decoder_a_to_2a.sv
// One-hot write-address decoder: a binary tree of decoder_1_to_2 cells,
// with the root enable gating the whole tree.

module decoder_1_to_2 (
  input  logic       ena,
  input  logic       sel,
  output logic [1:0] dec
);

  assign dec = ena ? (sel ? 2'b10 : 2'b01) : 2'b00;

endmodule

module decoder_a_to_2a #(
  parameter int unsigned A = 5
) (
  input  logic              ena,
  input  logic [A-1:0]      addr,
  output logic [2**A-1:0]   dec
);

  localparam int unsigned NOUT = 2**A;

  // Heap-ordered enables: node n feeds children 2n and 2n+1; leaves start at NOUT.
  logic [2*NOUT-1:1] tree;

  assign tree[1] = ena;

  for (genvar l = 0; l < A; l++) begin : g_level
    for (genvar j = 0; j < (2**l); j++) begin : g_node
      localparam int unsigned NODE = (2**l) + j;
      decoder_1_to_2 u_cell (
        .ena (tree[NODE]),
        .sel (addr[A-1-l]),
        .dec (tree[2*NODE+1 -: 2])
      );
    end
  end

  assign dec = tree[2*NOUT-1:NOUT];

endmodule

// File: rtl/register_file.sv
// 2**A x N register file: one synchronous write port, two combinational
// read ports, r0 hardwired to zero, same-cycle write-to-read forwarding.

module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned A = DEF_A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_ena,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [A-1:0] rd_addr0,
  input  logic [A-1:0] rd_addr1,
  output logic [N-1:0] rd_data0,
  output logic [N-1:0] rd_data1
);

  localparam int unsigned NREG = 2**A;

  logic [NREG-1:0] wr_strobe;
  logic            unused_strobe0;
  logic [N-1:0]    regs_q [NREG-1:1];
  logic [N-1:0]    regs_d [NREG-1:1];

  decoder_a_to_2a #(.A(A)) u_wr_dec (
    .ena  (wr_ena),
    .addr (wr_addr),
    .dec  (wr_strobe)
  );

  // r0 has no storage, so its strobe bit goes nowhere.
  assign unused_strobe0 = wr_strobe[0];

  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 1; k < NREG; k++) begin
      if (wr_strobe[k]) regs_d[k] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      for (int unsigned k = 1; k < NREG; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Read ports: zero register first, then the in-flight write, then storage.
  always_comb begin
    rd_data0 = '0;
    if (rd_addr0 != A'(REG_ZERO)) begin
      if (wr_ena && (wr_addr == rd_addr0)) rd_data0 = wr_data;
      else                                 rd_data0 = regs_q[rd_addr0];
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != A'(REG_ZERO)) begin
      if (wr_ena && (wr_addr == rd_addr1)) rd_data1 = wr_data;
      else                                 rd_data1 = regs_q[rd_addr1];
    end
  end

endmodule
